// File: rtl/bomberman_pkg.sv
// bomberman_pkg: arbiter state encoding and tile codes shared across the map logic
package bomberman_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_WRITE} arb_state_t;
    localparam int MAP_MEM_WIDTH = 2;
    localparam logic [MAP_MEM_WIDTH-1:0] TILE_EMPTY = 2'd0;
    localparam logic [MAP_MEM_WIDTH-1:0] TILE_WALL  = 2'd1;
    localparam logic [MAP_MEM_WIDTH-1:0] TILE_BRICK = 2'd2;
    localparam logic [MAP_MEM_WIDTH-1:0] TILE_BOMB  = 2'd3;
endpackage

// File: rtl/map_mem_arbiter_rr_pick.sv
// rr_pick: round-robin selector, first eligible requester at or above ptr (wrapping), minus excl
module rr_pick #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic [N-1:0] excl,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);
    logic [N-1:0] elig;
    assign elig  = req & ~excl;
    assign valid = |elig;
    always_comb begin
        gnt = '0;
        idx = '0;
        // Walk from farthest to nearest so the nearest eligible requester wins
        for (int k = N - 1; k >= 0; k--) begin
            if (elig[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx = W'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/map_mem_arbiter.sv
// map_mem_arbiter: shares the tile-map RAM between round-robin readers and a priority tile writer
module map_mem_arbiter
    import bomberman_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2,
    parameter int RD_LATENCY = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_grant,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_REQ-1:0]            rd_valid,
    input  logic                          wr_req,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_ack,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD) + 1;

    arb_state_t           state;
    logic [IW-1:0]        owner, ptr, owner_nxt, pick_ptr, pick_idx;
    logic [HW-1:0]        hold;
    logic [NUM_REQ-1:0]   pick_gnt, pick_excl, issue;
    logic [NUM_REQ-1:0]   tag_q [RD_LATENCY];
    logic                 pick_valid, granted, in_write, others, stay;

    assign granted   = state == ARB_GRANT;
    assign in_write  = state == ARB_WRITE && wr_req;
    assign issue     = rd_grant & rd_req;
    assign others    = |(rd_req & ~rd_grant) | wr_req;
    assign stay      = granted && rd_req[owner] && (hold < HW'(MAX_HOLD - 1) || !others);
    assign owner_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    // On release the search starts just past the owner, which is excluded when forced off
    assign pick_ptr  = granted ? owner_nxt : ptr;
    assign pick_excl = granted ? rd_grant : '0;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (rd_req),
        .ptr   (pick_ptr),
        .excl  (pick_excl),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold     <= '0;
            rd_grant <= '0;
        end else if (stay) begin
            hold <= (hold == HW'(MAX_HOLD - 1)) ? hold : hold + 1'b1;
        end else begin
            if (granted) ptr <= owner_nxt;
            // A write just serviced is not re-entered while its requester is still dropping wr_req
            if (wr_req && state != ARB_WRITE) begin
                state    <= ARB_WRITE;
                rd_grant <= '0;
            end else if (pick_valid) begin
                state    <= ARB_GRANT;
                owner    <= pick_idx;
                rd_grant <= pick_gnt;
                hold     <= '0;
            end else begin
                state    <= ARB_IDLE;
                rd_grant <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_q[0] <= rst ? '0 : issue;
        for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= rst ? '0 : tag_q[i-1];
    end

    assign rd_valid  = tag_q[RD_LATENCY-1];
    assign rd_data   = mem_rdata;
    assign wr_ack    = in_write;
    assign mem_we    = in_write;
    assign mem_en    = in_write | (|issue);
    assign mem_addr  = in_write ? wr_addr : (granted ? rd_addr[owner*ADDR_WIDTH +: ADDR_WIDTH] : '0);
    assign mem_wdata = in_write ? wr_data : DATA_WIDTH'(TILE_EMPTY);
endmodule

// File: tb/tb_map_mem_arbiter.sv
// tb_map_mem_arbiter: directed and random stimulus against a cycle-level behavioural arbiter model
module tb_map_mem_arbiter;
    localparam int N  = 4;
    localparam int MH = 16;

    logic        clk, rst;
    logic [3:0]  rd_req, rd_grant, rd_valid;
    logic [31:0] rd_addr;
    logic [1:0]  rd_data, wr_data, mem_wdata, mem_rdata;
    logic        wr_req, wr_ack, mem_en, mem_we;
    logic [7:0]  wr_addr, mem_addr;

    logic [1:0] ram    [256] = '{default: 2'd0};
    logic [1:0] shadow [256] = '{default: 2'd0};

    int checks = 0, errors = 0;
    int m_owner, m_ptr, m_held, m_tag;
    bit m_write, last_ack;
    logic [1:0] m_tag_data;

    map_mem_arbiter dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_write = 0; m_ptr = 0; m_held = 0; m_tag = -1; m_tag_data = 0;
    endtask

    // Called at a negedge with inputs already driven; compares, advances the model, waits a cycle
    task automatic cyc();
        int issue_o, from, excl;
        bit w, oth;
        logic [7:0] a_exp;
        #1;
        w = m_write && wr_req;
        issue_o = (m_owner >= 0 && rd_req[m_owner]) ? m_owner : -1;
        a_exp = w ? wr_addr : (m_owner >= 0 ? rd_addr[m_owner*8 +: 8] : 8'd0);
        check("rd_grant", rd_grant, m_owner >= 0 ? 32'(1) << m_owner : 0);
        check("wr_ack", wr_ack, w);
        check("mem_en", mem_en, w || issue_o >= 0);
        check("mem_we", mem_we, w);
        check("mem_addr", mem_addr, a_exp);
        check("mem_wdata", mem_wdata, w ? wr_data : 2'd0);
        check("rd_valid", rd_valid, m_tag >= 0 ? 32'(1) << m_tag : 0);
        if (m_tag >= 0) check("rd_data", rd_data, m_tag_data);
        last_ack = wr_ack;
        if (rst) model_reset();
        else begin
            if (w) shadow[wr_addr] = wr_data;
            m_tag = issue_o;
            m_tag_data = shadow[a_exp];
            oth = wr_req;
            for (int j = 0; j < N; j++) if (j != m_owner && rd_req[j]) oth = 1;
            if (issue_o >= 0 && (m_held < MH - 1 || !oth)) m_held++;
            else begin
                from = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
                excl = m_owner;
                if (m_owner >= 0) m_ptr = from;
                m_owner = -1;
                if (wr_req && !m_write) m_write = 1;
                else begin
                    m_write = 0;
                    for (int k = 0; k < N; k++)
                        if (m_owner < 0 && (from + k) % N != excl && rd_req[(from + k) % N]) begin
                            m_owner = (from + k) % N;
                            m_held = 0;
                        end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; rd_req = 0; wr_req = 0;
        cyc();
        rst = 0;
    endtask

    initial begin
        int cnt;
        rst = 1; rd_req = 0; rd_addr = 0; wr_req = 0; wr_addr = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 0;
        #1;
        check("rst_grant", rd_grant, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_en", mem_en, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(negedge clk);

        // Single requester: grant next cycle, data tag one cycle after issue
        rd_req = 4'b0001; rd_addr[7:0] = 8'd5;
        cyc();
        check("t1_grant", rd_grant, 4'b0001);
        check("t1_addr", mem_addr, 8'd5);
        cyc();
        check("t1_valid", rd_valid, 4'b0001);

        // All request, each releases after three cycles: 0,1,2,3,0 back to back
        do_reset();
        rd_req = 4'b1111;
        cyc();
        for (int g = 0; g < 5; g++) begin
            check("t2_order", rd_grant, 32'(1) << (g % N));
            repeat (3) cyc();
            rd_req[g % N] = 1'b0;
            cyc();
            rd_req[g % N] = 1'b1;
        end

        // Hold limit: owner forced off after MAX_HOLD cycles when another waits
        do_reset();
        rd_req = 4'b0101;
        cyc();
        cnt = 0;
        while (rd_grant == 4'b0001 && cnt < 40) begin
            cnt++;
            cyc();
        end
        check("t3_hold", cnt, MH);
        check("t3_next", rd_grant, 4'b0100);

        // Write waits for the reader, then a read returns the new code
        do_reset();
        rd_req = 4'b0010; rd_addr[15:8] = 8'd20;
        cyc();
        wr_req = 1; wr_addr = 8'd20; wr_data = 2'd2;
        repeat (3) cyc();
        check("t4_wait_grant", rd_grant, 4'b0010);
        check("t4_wait_ack", wr_ack, 0);
        rd_req = 0;
        cyc();
        check("t4_ack", wr_ack, 1);
        check("t4_we", mem_we, 1);
        cyc();
        wr_req = 0;
        check("t4_ack_once", wr_ack, 0);
        rd_req = 4'b0010;
        cyc();
        cyc();
        check("t4_valid", rd_valid, 4'b0010);
        check("t4_data", rd_data, 2'd2);

        // Tie in IDLE: write first, then the read grant
        do_reset();
        wr_req = 1; wr_addr = 8'd7; wr_data = 2'd3; rd_req = 4'b0010;
        cyc();
        check("t5_ack", wr_ack, 1);
        check("t5_nogrant", rd_grant, 0);
        wr_req = 0;
        cyc();
        check("t5_grant", rd_grant, 4'b0010);

        // Reset while a read is issued drops its tag
        do_reset();
        rd_req = 4'b0001; rd_addr[7:0] = 8'd9;
        cyc();
        rst = 1;
        cyc();
        rst = 0; rd_req = 0;
        #1;
        check("t6_grant", rd_grant, 0);
        check("t6_valid", rd_valid, 0);
        check("t6_en", mem_en, 0);
        check("t6_ack", wr_ack, 0);
        @(negedge clk);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) rd_req[i] = ~rd_req[i];
                if ($urandom_range(15) == 0) rd_addr[i*8 +: 8] = 8'($urandom_range(15));
            end
            if (last_ack) wr_req = 0;
            else if (!wr_req && $urandom_range(9) == 0) begin
                wr_req = 1;
                wr_addr = 8'($urandom_range(15));
                wr_data = 2'($urandom_range(3));
            end else if (wr_req && $urandom_range(63) == 0) wr_req = 0;
            rst = ($urandom_range(499) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
